// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the mental-arithmetic game; paces operand display,
// collects the player's answer, judges it against the running sum mod 100 and keeps score.
module game_round_ctrl #(
   parameter int NUM_OPS     = 5,
   parameter int HOLD_CYCLES = 10,
   parameter int GAP_CYCLES  = 2,
   parameter int ANS_TIMEOUT = 200,
   parameter int RESULT_HOLD = 10,
   parameter int ROUNDS      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       submit,
   input  logic [4:0] rand_num,
   input  logic [7:0] answer,
   output logic [7:0] disp_value,
   output logic [1:0] disp_mode,
   output logic [2:0] op_idx,
   output logic       busy,
   output logic       correct,
   output logic [2:0] score,
   output logic [3:0] round,
   output logic       game_over
);
   typedef enum logic [2:0] {IDLE, SHOW, GAP, ANSWER, JUDGE, RESULT, OVER} state_t;
   state_t      state;
   logic [2:0]  start_s, submit_s;
   logic [7:0]  acc, ans_q, target;
   logic [15:0] timer;
   logic        timed_out, start_edge, submit_edge, hit;
   assign start_edge  = start_s[1] & ~start_s[2];
   assign submit_edge = submit_s[1] & ~submit_s[2];
   assign target      = acc >= 8'd100 ? acc - 8'd100 : acc;
   assign hit         = (ans_q == target) & ~timed_out;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         start_s    <= '0;
         submit_s   <= '0;
         acc        <= '0;
         ans_q      <= '0;
         timer      <= '0;
         timed_out  <= 1'b0;
         disp_value <= '0;
         disp_mode  <= '0;
         op_idx     <= '0;
         busy       <= 1'b0;
         correct    <= 1'b0;
         score      <= '0;
         round      <= '0;
         game_over  <= 1'b0;
      end else begin
         start_s  <= {start_s[1:0], start};
         submit_s <= {submit_s[1:0], submit};
         timer    <= timer + 16'd1;
         correct  <= 1'b0;
         case (state)
            IDLE, OVER:
               if (start_edge) begin
                  state      <= SHOW;
                  timer      <= '0;
                  op_idx     <= '0;
                  round      <= '0;
                  score      <= '0;
                  acc        <= {3'b0, rand_num};
                  disp_value <= {3'b0, rand_num};
                  disp_mode  <= 2'd1;
                  busy       <= 1'b1;
                  game_over  <= 1'b0;
               end
            SHOW:
               if (timer == 16'(HOLD_CYCLES - 1)) begin
                  state      <= GAP;
                  timer      <= '0;
                  disp_value <= '0;
                  disp_mode  <= 2'd0;
               end
            GAP:
               if (timer == 16'(GAP_CYCLES - 1)) begin
                  timer <= '0;
                  if (op_idx == 3'(NUM_OPS - 1)) begin
                     state      <= ANSWER;
                     disp_value <= answer;
                     disp_mode  <= 2'd2;
                  end else begin
                     state      <= SHOW;
                     op_idx     <= op_idx + 3'd1;
                     acc        <= acc + {3'b0, rand_num};
                     disp_value <= {3'b0, rand_num};
                     disp_mode  <= 2'd1;
                  end
               end
            ANSWER: begin
               disp_value <= answer;
               // a submit edge takes priority over a timeout landing in the same cycle
               if (submit_edge) begin
                  state     <= JUDGE;
                  timer     <= '0;
                  ans_q     <= answer;
                  timed_out <= 1'b0;
               end else if (timer == 16'(ANS_TIMEOUT - 1)) begin
                  state     <= JUDGE;
                  timer     <= '0;
                  timed_out <= 1'b1;
               end
            end
            JUDGE: begin
               state      <= RESULT;
               timer      <= '0;
               correct    <= hit;
               score      <= score + {2'b0, hit & (score != 3'd7)};
               disp_value <= target;
               disp_mode  <= 2'd3;
            end
            RESULT:
               if (timer == 16'(RESULT_HOLD - 1)) begin
                  timer <= '0;
                  if (round == 4'(ROUNDS - 1)) begin
                     state      <= OVER;
                     busy       <= 1'b0;
                     game_over  <= 1'b1;
                     disp_value <= {5'b0, score};
                     disp_mode  <= 2'd3;
                  end else begin
                     state      <= SHOW;
                     round      <= round + 4'd1;
                     op_idx     <= '0;
                     acc        <= {3'b0, rand_num};
                     disp_value <= {3'b0, rand_num};
                     disp_mode  <= 2'd1;
                  end
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: randomized scoreboard bench for game_round_ctrl; a 4-round and a
// 9-round instance share stimulus, results are predicted from the game rules.
module tb_game_round_ctrl;
   localparam int NUM_OPS = 5;
   localparam int K_OK = 0, K_WRONG = 1, K_TIMEOUT = 2, K_TIE = 3, K_GLITCH = 4, K_ABORT = 5;
   typedef struct {int c; int s; int d;} exp_t;
   logic       clk = 0, rst = 1, start = 0, submit = 0, sel9 = 0;
   logic [4:0] rand_num = 0;
   logic [7:0] answer = 0;
   logic [7:0] d4, d9, v_disp;
   logic [1:0] m4, m9, v_mode;
   logic [2:0] o4, o9, s4, s9, v_op, v_score;
   logic [3:0] r4, r9, v_round;
   logic       b4, b9, c4, c9, g4, g9, v_busy, v_correct;
   logic       prev = 0, just = 0;
   int         total = 0, bad = 0, mscore = 0;
   exp_t       q[$];

   game_round_ctrl dut (.clk(clk), .rst(rst), .start(start), .submit(submit), .rand_num(rand_num),
      .answer(answer), .disp_value(d4), .disp_mode(m4), .op_idx(o4), .busy(b4), .correct(c4),
      .score(s4), .round(r4), .game_over(g4));
   game_round_ctrl #(.ROUNDS(9)) dut9 (.clk(clk), .rst(rst), .start(start), .submit(submit),
      .rand_num(rand_num), .answer(answer), .disp_value(d9), .disp_mode(m9), .op_idx(o9),
      .busy(b9), .correct(c9), .score(s9), .round(r9), .game_over(g9));

   assign v_disp    = sel9 ? d9 : d4;
   assign v_mode    = sel9 ? m9 : m4;
   assign v_op      = sel9 ? o9 : o4;
   assign v_score   = sel9 ? s9 : s4;
   assign v_round   = sel9 ? r9 : r4;
   assign v_busy    = sel9 ? b9 : b4;
   assign v_correct = sel9 ? c9 : c4;

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic begin_game();
      mscore = 0;
      start = 1;
      tick();
      tick();
      start = 0;
   endtask

   task automatic check_over4(input int exp_score);
      chk("over_flag", int'(g4), 1);
      chk("over_value", int'(d4), exp_score);
      chk("over_busy", int'(b4), 0);
      chk("over_mode", int'(m4), 3);
   endtask

   // Entered one cycle before the SHOW-entry edge; leaves one cycle before the next one.
   task automatic play_round(input int r, input int fr, input int kind, input int ans_in, input bit ov);
      int sum, v, a, tgt;
      bit ok;
      sum = 0;
      for (int i = 0; i < NUM_OPS; i++) begin
         v = fr >= 0 ? fr : int'($urandom_range(0, 31));
         rand_num = 5'(v);
         sum += v;
         tick();
         chk("op_idx", int'(v_op), i);
         chk("op_value", int'(v_disp), v);
         chk("op_mode", int'(v_mode), 1);
         if (i == 0) begin
            chk("round_idx", int'(v_round), r);
            chk("score_at_start", int'(v_score), mscore);
            chk("busy", int'(v_busy), 1);
            if (ov) check_over4(4);
         end
         for (int j = 0; j < (i == NUM_OPS - 1 ? 12 : 11); j++) begin
            rand_num = 5'($urandom);
            if (kind == K_GLITCH && i == 1) begin
               start  = j < 4;
               submit = j < 4;
            end
            tick();
            if (j == 8) chk("show_len", int'(v_mode), 1);
            if (j == 9) chk("gap_blank", int'({v_mode, v_disp}), 0);
         end
      end
      chk("answer_entry", int'(v_mode), 2);
      tgt = sum % 100;
      if (kind == K_ABORT) return;
      a = int'($urandom_range(0, 255));
      answer = 8'(a);
      tick();
      chk("answer_echo", int'(v_disp), a);
      a = ans_in >= 0 ? ans_in : (kind == K_WRONG ? (tgt + 1 + int'($urandom_range(0, 98))) % 100 : tgt);
      answer = 8'(a);
      ok = (a == tgt) && kind != K_TIMEOUT;
      if (ok && mscore < 7) mscore++;
      q.push_back('{c: int'(ok), s: mscore, d: tgt});
      if (kind == K_TIMEOUT || kind == K_TIE) begin
         repeat (196) tick();
         if (kind == K_TIE) submit = 1;
         tick();
         tick();
         submit = 0;
         chk("answer_last", int'(v_mode), 2);
         tick();
         chk("judge_cycle", int'(v_mode), 2);
         answer = 8'($urandom);
         tick();
      end else begin
         submit = 1;
         tick();
         tick();
         submit = 0;
         tick();
         answer = 8'($urandom);
         tick();
      end
      repeat (9) tick();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 0;
            just = 0;
         end else begin
            if (just) chk("correct_pulse_len", int'(v_correct), 0);
            just = 0;
            if (v_busy && v_mode == 2'd3 && !prev) begin
               chk("result_queued", int'(q.size() > 0), 1);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  chk("correct", int'(v_correct), e.c);
                  chk("score", int'(v_score), e.s);
                  chk("result_value", int'(v_disp), e.d);
               end
               just = 1;
            end
            prev = v_busy && v_mode == 2'd3;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      chk("reset_outs", int'({d4, m4, o4, b4, c4, s4, r4, g4}), 0);
      chk("reset_outs9", int'({d9, m9, o9, b9, c9, s9, r9, g9}), 0);
      rst = 0;
      begin_game();
      play_round(0, 20, K_OK, 0, 0);
      play_round(1, 31, K_WRONG, 54, 0);
      play_round(2, 31, K_OK, 55, 0);
      play_round(3, -1, K_TIMEOUT, -1, 0);
      tick();
      check_over4(mscore);
      begin_game();
      play_round(0, 31, K_TIE, 55, 0);
      play_round(1, -1, K_GLITCH, -1, 0);
      play_round(2, -1, K_ABORT, -1, 0);
      #2 rst = 1;
      #1;
      chk("async_reset", int'({d4, m4, o4, b4, c4, s4, r4, g4}), 0);
      chk("async_reset9", int'({d9, m9, o9, b9, c9, s9, r9, g9}), 0);
      mscore = 0;
      sel9 = 1;
      start = 1;
      tick();
      tick();
      rst = 0;
      tick();
      tick();
      for (int r = 0; r < 9; r++) play_round(r, -1, K_OK, -1, r == 4);
      tick();
      chk("over9_flag", int'(g9), 1);
      chk("over9_value", int'(d9), 7);
      chk("over9_score", int'(s9), 7);
      chk("over9_busy", int'(b9), 0);
      chk("held_start_over", int'(g4), 1);
      chk("held_start_round", int'(r4), 3);
      tick();
      chk("queue_drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round sequencer for the mental-arithmetic game. It draws operands from the 5-bit LFSR and paces their display, then waits for the player's answer. It judges the answer against the running sum modulo 100 and keeps score across a fixed number of rounds. It replaces the free-running phase counter with an explicit FSM, synchronized button handshakes and an answer timeout. `disp_value` feeds the BCD converter.

## Interface
- `NUM_OPS`, 5: operands per round (1..6)
- `HOLD_CYCLES`, 10: cycles each operand is shown
- `GAP_CYCLES`, 2: blank cycles after each operand
- `ANS_TIMEOUT`, 200: max cycles in ANSWER
- `RESULT_HOLD`, 10: cycles the sum is shown
- `ROUNDS`, 4: rounds per game (1..15)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  raw button, async level
- `submit`  in  1  raw button, async level
- `rand_num`  in  5  LFSR output
- `answer`  in  8  player switches
- `disp_value`  out  8  value to BCD converter
- `disp_mode`  out  2  0 = blank, 1 = operand, 2 = answer echo, 3 = sum/score
- `op_idx`  out  3  index of current operand
- `busy`  out  1  high in SHOW..RESULT
- `correct`  out  1  one-cycle pulse on a correct judgement
- `score`  out  3  correct rounds, saturates at 7
- `round`  out  4  current round, 0-based
- `game_over`  out  1  high in OVER

## Operation
- `start` and `submit` each pass through a 2-flop synchronizer plus a third flop; edge = s2 & ~s3.
- IDLE: outputs at reset values. On a start edge → SHOW with `op_idx`=0, `round`=0, `score`=0, `acc`<=`rand_num`, `disp_value`<=`rand_num`, mode 1.
- SHOW: holds for HOLD_CYCLES cycles, then → GAP with `disp_value`=0, mode 0.
- GAP: holds for GAP_CYCLES cycles, then:
  - if `op_idx`==NUM_OPS-1 → ANSWER;
  - else → SHOW with `op_idx`+1, `acc`<=`acc`+`rand_num`, `disp_value`<=`rand_num`.
- `acc` is 8-bit; its maximum is 186 (6×31), so no overflow.
- ANSWER: `disp_value`<=`answer` every cycle, mode 2.
  - Submit edge → JUDGE, `ans_q`<=`answer`, `timed_out`<=0.
  - Timer reaching ANS_TIMEOUT-1 → JUDGE, `timed_out`<=1.
  - Submit edge wins if both occur in the same cycle.
- JUDGE (1 cycle):
  - `target` = `acc`>=100 ? `acc`-100 : `acc`.
  - `correct`<=(`ans_q`==`target`) & ~`timed_out`.
  - `score`<=`score`+1 if correct, unless already 7.
  - `disp_value`<=`target`, mode 3 → RESULT.
- RESULT: holds for RESULT_HOLD cycles, then:
  - if `round`==ROUNDS-1 → OVER;
  - else `round`+1, `op_idx`=0, `acc`<=`rand_num` → SHOW.
- OVER: `game_over`=1, `disp_value`={5'b0,`score`}, mode 3. A start edge behaves as in IDLE.
- Start edges are ignored in SHOW..RESULT. Submit edges are ignored outside ANSWER.

## Timing
- Reset values: every output 0, FSM in IDLE, synchronizer flops 0, `acc`=0, timer=0.
- `rst` asserted mid-operation clears everything immediately, with no completion of the round.
- Button latency: input high before edge k → edge flag high after edge k+1 → FSM transitions at edge k+2. A held button produces exactly one edge.
- State durations are exact:
  - SHOW = HOLD_CYCLES cycles
  - GAP = GAP_CYCLES cycles
  - RESULT = RESULT_HOLD cycles
  - JUDGE = 1 cycle
  - ANSWER ≤ ANS_TIMEOUT cycles
- The timer clears on every state entry.
- `correct` is high for exactly the first cycle of RESULT (registered in JUDGE).
- `score` updates at the same edge as `correct`.
- Round time with defaults, excluding ANSWER: 5×(10+2)+1+10 = 71 cycles.
- `rand_num` is sampled only on SHOW-entry edges.

## Test plan
- Correct answer: `rand_num` held at 20, start pulse, `answer`=0 (100 mod 100), submit in ANSWER → `correct` pulse, `score`=1, `disp_value`=0, mode 3.
- Wrong answer: `rand_num` held at 31 (sum 155 → 55), `answer`=54, submit → `correct`=0, `score`=0, `disp_value`=55; then repeat with `answer`=55 → `score`=1.
- Timeout: `rand_num`=31, `answer`=55, no submit → JUDGE exactly 200 cycles after ANSWER entry, `correct`=0.
- Tie-break: submit edge in the final timeout cycle with `answer`=55 → `correct`=1.
- Full game: ROUNDS=4, all correct → `game_over`=1, `disp_value`=4, `busy`=0. Start → `round`=0, `score`=0. With ROUNDS=9, all correct → `score` saturates at 7.
- Reset mid-ANSWER → all outputs 0, IDLE. Start held high across reset release → one new game only. Start during SHOW and submit during SHOW → no effect on state, `op_idx` or `score`.
